// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial operand/control stage driving an external 4-bit adder slice.
// Optional subtract mode enabled by defining NSA_SUBTRACT_EN (adds the Sub port).
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Run,
`ifdef NSA_SUBTRACT_EN
  input  logic             Sub,
`endif
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e                    state_q, state_d;
  logic [NIBBLES-1:0][3:0]   a_q, a_d;
  logic [NIBBLES-1:0][3:0]   b_q, b_d;
  logic [NIBBLES-1:0][3:0]   sum_q, sum_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      cout_q, cout_d;
  logic                      run_q;
  logic                      start;
  logic                      sub_mode;
  logic                      sub_start;

`ifdef NSA_SUBTRACT_EN
  logic sub_q, sub_d;

  assign sub_mode  = sub_q;
  assign sub_start = Sub;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`else
  assign sub_mode  = 1'b0;
  assign sub_start = 1'b0;
`endif

  assign start = Run & ~run_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      run_q   <= Run;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
`ifdef NSA_SUBTRACT_EN
    sub_d     = sub_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        // Loads win over a coincident Run edge.
        if (LoadA || LoadB) begin
          if (LoadA) a_d = Din;
          if (LoadB) b_d = Din;
          state_d = StIdle;
        end else if (start) begin
          idx_d   = '0;
          carry_d = sub_start;
`ifdef NSA_SUBTRACT_EN
          sub_d   = Sub;
`endif
          state_d = StAdd;
        end
      end

      StAdd: begin
        slice_a        = a_q[idx_q];
        slice_b        = b_q[idx_q] ^ {4{sub_mode}};
        slice_cin      = carry_q;
        sum_d[idx_q]   = slice_s;
        carry_d        = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Busy = (state_q == StAdd);
  assign Done = (state_q == StDone);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl; the 4-bit slice is modelled here.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             Clk;
  logic             Reset_n;
  logic [WIDTH-1:0] Din;
  logic             LoadA, LoadB, Run;
`ifdef NSA_SUBTRACT_EN
  logic             Sub;
`endif
  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_cin, slice_cout;
  logic [WIDTH-1:0] Sum;
  logic             Cout, Busy, Done;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: operand registers as seen by the specification.
  logic [WIDTH-1:0] m_a, m_b;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Din        (Din),
    .LoadA      (LoadA),
    .LoadB      (LoadB),
    .Run        (Run),
`ifdef NSA_SUBTRACT_EN
    .Sub        (Sub),
`endif
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_cout (slice_cout),
    .Sum        (Sum),
    .Cout       (Cout),
    .Busy       (Busy),
    .Done       (Done)
  );

  // External 4-bit ripple-carry slice.
  assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic exp_cin(input logic [63:0] a, input logic [63:0] b,
                                   input bit sub, input int i);
    logic [63:0] mask, al, bl;
    if (i == 0) return sub;
    mask = (64'd1 << (4 * i)) - 64'd1;
    al   = a & mask;
    bl   = b & mask;
    if (sub) return al >= bl;
    return ((al + bl) >> (4 * i)) != 64'd0;
  endfunction

  task automatic do_load(input bit la, input bit lb, input logic [WIDTH-1:0] d);
    LoadA = la;
    LoadB = lb;
    Din   = d;
    tick();
    LoadA = 1'b0;
    LoadB = 1'b0;
    if (la) m_a = d;
    if (lb) m_b = d;
    chk("load_done_clr", Done, 1'b0);
    chk("load_busy", Busy, 1'b0);
  endtask

  // One operation: start edge, NIBBLES add cycles, then DONE.
  task automatic run_op(input bit sub, input bit hold, input bit ld_during);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] e_sum;
    logic             e_cout;
    logic [63:0]      a64, b64;
    if (sub) begin
      e_sum  = m_a - m_b;
      e_cout = (m_a >= m_b);
    end else begin
      full   = {1'b0, m_a} + {1'b0, m_b};
      e_sum  = full[WIDTH-1:0];
      e_cout = full[WIDTH];
    end
    a64 = 64'(m_a);
    b64 = 64'(m_b);
`ifdef NSA_SUBTRACT_EN
    Sub = sub;
`endif
    Run = 1'b1;
    chk("pre_busy", Busy, 1'b0);
    tick();
    if (!hold) Run = 1'b0;
`ifdef NSA_SUBTRACT_EN
    Sub = ~sub;
`endif
    for (int i = 0; i < int'(NIBBLES); i++) begin
      chk("busy", Busy, 1'b1);
      chk("done_in_add", Done, 1'b0);
      chk("slice_a", slice_a, (a64 >> (4 * i)) & 64'hF);
      chk("slice_b", slice_b, ((sub ? ~b64 : b64) >> (4 * i)) & 64'hF);
      chk("slice_cin", slice_cin, exp_cin(a64, b64, sub, i));
      if (ld_during) begin
        LoadA = 1'b1;
        LoadB = 1'b1;
        Din   = WIDTH'(16'hAAAA);
      end
      tick();
      LoadA = 1'b0;
      LoadB = 1'b0;
    end
    chk("done", Done, 1'b1);
    chk("busy_end", Busy, 1'b0);
    chk("sum", Sum, e_sum);
    chk("cout", Cout, e_cout);
    chk("idle_slice_cin", slice_cin, 1'b0);
    chk("idle_slice_a", slice_a, 4'h0);
    if (hold) begin
      repeat (15) begin
        tick();
        chk("hold_busy", Busy, 1'b0);
        chk("hold_done", Done, 1'b1);
      end
      chk("hold_sum", Sum, e_sum);
      Run = 1'b0;
      tick();
    end
  endtask

  initial begin
    bit sub;
    Reset_n = 1'b0;
    Din     = '0;
    LoadA   = 1'b0;
    LoadB   = 1'b0;
    Run     = 1'b0;
`ifdef NSA_SUBTRACT_EN
    Sub     = 1'b0;
`endif
    m_a = '0;
    m_b = '0;
    repeat (3) tick();
    chk("rst_sum", Sum, '0);
    chk("rst_cout", Cout, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_slice_b", slice_b, 4'h0);
    Reset_n = 1'b1;
    tick();

    // Basic add
    do_load(1, 0, 16'h1234);
    do_load(0, 1, 16'h4321);
    run_op(0, 0, 0);
    chk("basic_sum", Sum, 16'h5555);

    // Full carry ripple
    do_load(1, 0, 16'hFFFF);
    do_load(0, 1, 16'h0001);
    run_op(0, 0, 0);
    chk("ripple_cout", Cout, 1'b1);

    // Held Run yields a single add
    do_load(1, 0, 16'h00FF);
    do_load(0, 1, 16'h0F01);
    run_op(0, 1, 0);
    chk("held_sum", Sum, 16'h1000);

    // Loads during ADD ignored, then LoadA in DONE
    run_op(0, 0, 1);
    chk("ld_add_sum", Sum, 16'h1000);
    do_load(1, 0, 16'hAAAA);
    run_op(0, 0, 0);
    chk("newa_sum", Sum, 16'hB9AB);

    // Asynchronous reset in the second ADD cycle
    do_load(1, 1, 16'h1234);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    tick();
    chk("mid_busy", Busy, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mr_busy", Busy, 1'b0);
    chk("mr_done", Done, 1'b0);
    chk("mr_sum", Sum, '0);
    chk("mr_cout", Cout, 1'b0);
    chk("mr_slice_a", slice_a, 4'h0);
    m_a = '0;
    m_b = '0;
    tick();
    Reset_n = 1'b1;
    tick();
    run_op(0, 0, 0);
    chk("post_rst_zero", Sum, '0);
    do_load(1, 1, 16'h7777);
    run_op(0, 0, 0);

    // Loads coincident with the Run edge take priority
    LoadA = 1'b1;
    LoadB = 1'b1;
    Din   = 16'h8000;
    Run   = 1'b1;
    tick();
    LoadA = 1'b0;
    LoadB = 1'b0;
    m_a   = 16'h8000;
    m_b   = 16'h8000;
    repeat (3) begin
      tick();
      chk("simul_no_start", Busy, 1'b0);
    end
    Run = 1'b0;
    tick();
    run_op(0, 0, 0);
    chk("simul_sum", Sum, 16'h0000);
    chk("simul_cout", Cout, 1'b1);

`ifdef NSA_SUBTRACT_EN
    do_load(1, 0, 16'h0005);
    do_load(0, 1, 16'h0007);
    run_op(1, 0, 0);
    chk("sub_sum0", Sum, 16'hFFFE);
    do_load(1, 0, 16'h0007);
    do_load(0, 1, 16'h0005);
    run_op(1, 0, 0);
    chk("sub_sum1", Sum, 16'h0002);
    chk("sub_cout1", Cout, 1'b1);
`endif

    // Randomized operands
    for (int k = 0; k < 30; k++) begin
      sub = 1'b0;
`ifdef NSA_SUBTRACT_EN
      sub = 1'($urandom_range(0, 1));
`endif
      case ($urandom_range(0, 3))
        0: do_load(1, 1, WIDTH'($urandom));
        1: do_load(1, 0, WIDTH'($urandom));
        2: do_load(0, 1, WIDTH'($urandom));
        default: ;
      endcase
      run_op(sub, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
